// File: rtl/zamek_pkg.sv
// Shared constants for the code-lock sequencer.
//   ST_*     : debug state encoding driven on zamek_ctrl.state
//   DIGIT_W  : width of one BCD code digit
package zamek_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [1:0] ST_ENTRY   = 2'd0;
  localparam logic [1:0] ST_CHECK   = 2'd1;
  localparam logic [1:0] ST_OPEN    = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

endpackage

// File: rtl/zamek_ctrl_cnt.sv
// Modulo-N up-counter with synchronous clear (clear wins over enable).
//   clk : clock
//   clr : synchronous clear to 0
//   ce  : count enable, wraps MODULUS-1 -> 0
//   q   : registered count
module zamek_ctrl_cnt #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next count
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ce) begin
      q_d = (q_q == WIDTH'(MODULUS - 1)) ? '0 : q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/zamek_ctrl.sv
// Code-lock sequencer: digit entry, code check, timed open window and
// timed alarm lockout after MAX_ERR consecutive wrong codes.
//   clk, clr_n      : clock, synchronous active-low reset
//   btn_inc/ok/lock : single-cycle button pulses
//   code            : stored BCD code, position 0 in the MS nibble
//   digit, pos      : digit being entered and its index
//   unlocked, alarm : lock open / lockout active (never both)
//   err_cnt         : consecutive wrong entries
//   state           : debug state (ENTRY/CHECK/OPEN/LOCKOUT)
module zamek_ctrl
  import zamek_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned MAX_ERR        = 3,
  parameter int unsigned OPEN_CYCLES    = 100,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  localparam int unsigned PW   = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int unsigned EW   = $clog2(MAX_ERR + 1),
  localparam int unsigned TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES,
  localparam int unsigned TW   = $clog2(TMAX + 1)
) (
  input  logic                        clk,
  input  logic                        clr_n,
  input  logic                        btn_inc,
  input  logic                        btn_ok,
  input  logic                        btn_lock,
  input  logic [DIGIT_W*DIGITS-1:0]   code,
  output logic [DIGIT_W-1:0]          digit,
  output logic [PW-1:0]               pos,
  output logic                        unlocked,
  output logic                        alarm,
  output logic [EW-1:0]               err_cnt,
  output logic [1:0]                  state
);

  logic [1:0]         state_d,    state_q;
  logic [PW-1:0]      pos_d,      pos_q;
  logic               mismatch_d, mismatch_q;
  logic [TW-1:0]      timer_d,    timer_q;
  logic               unlocked_d, unlocked_q;
  logic               alarm_d,    alarm_q;
  logic [EW-1:0]      err_cnt_d,  err_cnt_q;

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] code_nib_c;
  logic               commit_c;
  logic               abort_c;
  logic               check_exit_c;
  logic               digit_ce_c;
  logic               digit_clr_c;

  // Code nibble at the current position (position 0 is the MS nibble)
  always_comb begin
    code_nib_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (pos_q == PW'(i)) begin
        code_nib_c = code[DIGIT_W*(DIGITS-1-i) +: DIGIT_W];
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    mismatch_d   = mismatch_q;
    timer_d      = timer_q;
    unlocked_d   = unlocked_q;
    alarm_d      = alarm_q;
    err_cnt_d    = err_cnt_q;
    commit_c     = 1'b0;
    abort_c      = 1'b0;
    check_exit_c = 1'b0;
    digit_ce_c   = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        digit_ce_c = btn_inc & ~btn_ok & ~btn_lock;
        if (btn_lock) begin
          abort_c    = 1'b1;
          pos_d      = '0;
          mismatch_d = 1'b0;
        end else if (btn_ok) begin
          // Digit is at most 9, so a code nibble above 9 always mismatches
          commit_c   = 1'b1;
          mismatch_d = mismatch_q | (digit_q != code_nib_c);
          if (pos_q == PW'(DIGITS - 1)) begin
            pos_d   = '0;
            state_d = ST_CHECK;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end
      end

      ST_CHECK: begin
        check_exit_c = 1'b1;
        mismatch_d   = 1'b0;
        if (!mismatch_q) begin
          err_cnt_d  = '0;
          timer_d    = TW'(OPEN_CYCLES);
          unlocked_d = 1'b1;
          state_d    = ST_OPEN;
        end else if (32'(err_cnt_q) + 32'd1 == MAX_ERR) begin
          err_cnt_d = EW'(MAX_ERR);
          timer_d   = TW'(LOCKOUT_CYCLES);
          alarm_d   = 1'b1;
          state_d   = ST_LOCKOUT;
        end else begin
          err_cnt_d = err_cnt_q + EW'(1);
          state_d   = ST_ENTRY;
        end
      end

      ST_OPEN: begin
        if (btn_lock || timer_q == TW'(1)) begin
          unlocked_d = 1'b0;
          timer_d    = '0;
          state_d    = ST_ENTRY;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == TW'(1)) begin
          alarm_d   = 1'b0;
          err_cnt_d = '0;
          timer_d   = '0;
          state_d   = ST_ENTRY;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: state_d = ST_ENTRY;
    endcase

    digit_clr_c = ~clr_n | commit_c | abort_c | check_exit_c;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q    <= ST_ENTRY;
      pos_q      <= '0;
      mismatch_q <= 1'b0;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      mismatch_q <= mismatch_d;
      timer_q    <= timer_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Digit entry counter
  zamek_ctrl_cnt #(
    .WIDTH   (DIGIT_W),
    .MODULUS (10)
  ) u_digit_cnt (
    .clk (clk),
    .clr (digit_clr_c),
    .ce  (digit_ce_c),
    .q   (digit_q)
  );

  assign digit    = digit_q;
  assign pos      = pos_q;
  assign unlocked = unlocked_q;
  assign alarm    = alarm_q;
  assign err_cnt  = err_cnt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_zamek_ctrl.sv
// Bench for zamek_ctrl: directed scenarios with literal expectations plus
// randomized button traffic, all outputs compared every cycle to a model.
module tb_zamek_ctrl;

  localparam int D  = 4;
  localparam int ME = 3;
  localparam int OC = 8;
  localparam int LC = 16;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_ok = 1'b0;
  logic        btn_lock = 1'b0;
  logic [15:0] code = 16'h1234;
  logic [3:0]  digit;
  logic [1:0]  pos;
  logic        unlocked;
  logic        alarm;
  logic [1:0]  err_cnt;
  logic [1:0]  state;

  zamek_ctrl #(
    .DIGITS         (D),
    .MAX_ERR        (ME),
    .OPEN_CYCLES    (OC),
    .LOCKOUT_CYCLES (LC)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .btn_inc  (btn_inc),
    .btn_ok   (btn_ok),
    .btn_lock (btn_lock),
    .code     (code),
    .digit    (digit),
    .pos      (pos),
    .unlocked (unlocked),
    .alarm    (alarm),
    .err_cnt  (err_cnt),
    .state    (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model: mode 0 entry, 1 check, 2 open, 3 lockout
  int m_mode = 0, m_digit = 0, m_pos = 0, m_err = 0, m_left = 0;
  bit m_unl = 1'b0, m_alm = 1'b0;
  int entered[D];

  function automatic bit entry_matches();
    logic [15:0] sh;
    for (int i = 0; i < D; i++) begin
      sh = code >> (4 * (D - 1 - i));
      if (entered[i] != int'(sh[3:0])) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!clr_n) begin
      m_mode = 0; m_digit = 0; m_pos = 0; m_err = 0; m_left = 0;
      m_unl = 1'b0; m_alm = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (btn_lock) begin
            m_digit = 0; m_pos = 0;
          end else if (btn_ok) begin
            entered[m_pos] = m_digit;
            m_digit = 0;
            if (m_pos == D - 1) begin m_pos = 0; m_mode = 1; end
            else m_pos = m_pos + 1;
          end else if (btn_inc) begin
            m_digit = (m_digit + 1) % 10;
          end
        end
        1: begin
          if (entry_matches()) begin
            m_err = 0; m_unl = 1'b1; m_left = OC; m_mode = 2;
          end else if (m_err + 1 == ME) begin
            m_err = ME; m_alm = 1'b1; m_left = LC; m_mode = 3;
          end else begin
            m_err = m_err + 1; m_mode = 0;
          end
        end
        2: begin
          m_left = m_left - 1;
          if (btn_lock || m_left == 0) begin m_unl = 1'b0; m_mode = 0; end
        end
        default: begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_alm = 1'b0; m_err = 0; m_mode = 0; end
        end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [11:0] act, exp;
    if (chk_en) begin
      act = {digit, pos, unlocked, alarm, err_cnt, state};
      exp = {4'(m_digit), 2'(m_pos), m_unl, m_alm, 2'(m_err), 2'(m_mode)};
      total++;
      if (act !== exp || (unlocked && alarm)) begin
        bad++;
        $display("FAIL model t=%0t got d=%0d p=%0d u=%0b a=%0b e=%0d s=%0d expected d=%0d p=%0d u=%0b a=%0b e=%0d s=%0d",
                 $time, digit, pos, unlocked, alarm, err_cnt, state,
                 m_digit, m_pos, m_unl, m_alm, m_err, m_mode);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock with the given button levels; returns at the next negedge
  task automatic step(input bit inc, input bit ok, input bit lock);
    btn_inc = inc; btn_ok = ok; btn_lock = lock;
    @(negedge clk);
    btn_inc = 1'b0; btn_ok = 1'b0; btn_lock = 1'b0;
  endtask

  task automatic enter_digit(input int d);
    repeat (d) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic enter_code(input int a, input int b, input int c, input int e);
    enter_digit(a); enter_digit(b); enter_digit(c); enter_digit(e);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_digit", int'(digit), 0);
    check("rst_unlocked", int'(unlocked), 0);
    check("rst_state", int'(state), 0);
    clr_n = 1'b1;

    // Correct entry and open window length
    enter_code(1, 2, 3, 4);
    check("check_state", int'(state), 1);
    step(1'b0, 1'b0, 1'b0);
    check("open_start", int'(unlocked), 1);
    n = 0;
    while (unlocked === 1'b1 && n < 50) begin n++; step(1'b0, 1'b0, 1'b0); end
    check("open_len", n, 8);
    check("open_end_state", int'(state), 0);
    check("open_end_pos", int'(pos), 0);

    // Wrap and simultaneous inc+ok
    repeat (10) step(1'b1, 1'b0, 1'b0);
    check("wrap_digit0", int'(digit), 0);
    step(1'b1, 1'b0, 1'b0);
    check("wrap_digit1", int'(digit), 1);
    step(1'b1, 1'b1, 1'b0);
    check("incok_digit", int'(digit), 0);
    check("incok_pos", int'(pos), 1);
    enter_digit(2); enter_digit(3); enter_digit(4);
    step(1'b0, 1'b0, 1'b0);
    check("incok_open", int'(unlocked), 1);
    step(1'b0, 1'b0, 1'b1);
    check("relock", int'(unlocked), 0);

    // Three wrong entries -> lockout
    for (int k = 1; k <= 2; k++) begin
      enter_code(1, 2, 3, 5);
      step(1'b0, 1'b0, 1'b0);
      check("wrong_err", int'(err_cnt), k);
    end
    enter_code(1, 2, 3, 5);
    step(1'b0, 1'b0, 1'b0);
    check("lock_alarm", int'(alarm), 1);
    check("lock_err", int'(err_cnt), 3);
    n = 0;
    while (alarm === 1'b1 && n < 100) begin
      n++;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check("lock_len", n, 16);
    check("lock_end_err", int'(err_cnt), 0);
    check("lock_end_state", int'(state), 0);

    // Abort keeps err_cnt; correct code clears it; early relock on 3rd open cycle
    enter_code(9, 9, 9, 9);
    step(1'b0, 1'b0, 1'b0);
    enter_digit(1); enter_digit(2);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("abort_pos", int'(pos), 0);
    check("abort_digit", int'(digit), 0);
    check("abort_err", int'(err_cnt), 1);
    enter_code(1, 2, 3, 4);
    step(1'b0, 1'b0, 1'b0);
    check("errclr_unl", int'(unlocked), 1);
    check("errclr_err", int'(err_cnt), 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("early_relock", int'(unlocked), 0);

    // Reset during OPEN and during LOCKOUT
    enter_code(1, 2, 3, 4);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    check("pre_rst_open", int'(unlocked), 1);
    clr_n = 1'b0; step(1'b0, 1'b0, 1'b0); clr_n = 1'b1;
    check("rst_open_unl", int'(unlocked), 0);
    check("rst_open_state", int'(state), 0);
    repeat (3) begin enter_code(5, 5, 5, 5); step(1'b0, 1'b0, 1'b0); end
    step(1'b0, 1'b0, 1'b0);
    check("pre_rst_alarm", int'(alarm), 1);
    clr_n = 1'b0; step(1'b0, 1'b0, 1'b0); clr_n = 1'b1;
    check("rst_lock_alarm", int'(alarm), 0);
    check("rst_lock_err", int'(err_cnt), 0);
    check("rst_lock_state", int'(state), 0);

    // Code nibble above 9 can never match
    code = 16'h1A34;
    enter_code(1, 0, 3, 4);
    step(1'b0, 1'b0, 1'b0);
    check("bignib_err", int'(err_cnt), 1);
    check("bignib_unl", int'(unlocked), 0);
    code = 16'h1234;

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: enter_code(1, 2, 3, 4);
        1: enter_code($urandom_range(0, 9), $urandom_range(0, 9),
                      $urandom_range(0, 9), $urandom_range(0, 9));
        default: begin
          repeat (30) begin
            clr_n = ($urandom_range(0, 199) != 0);
            step(($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 19) == 0));
            clr_n = 1'b1;
          end
        end
      endcase
    end
    repeat (20) step(1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
